// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-3 master byte engine.
package spi_pkg;

   localparam int BYTE_W = 8;
   localparam bit CPOL   = 1'b1;
   localparam bit CPHA   = 1'b1;

   typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, GAP} spi_state_e;

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/spi_master_timer.sv
// Loadable down-counter: loading N makes done rise on the N-th cycle after the load
// and stay high until the next load.
module spi_master_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= load_val - W'(1);
      else if (cnt != '0)
         cnt <= cnt - W'(1);
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/spi_master_byte.sv
// SPI mode-3 (CPOL=1, CPHA=1) master byte engine, MSB first, multi-byte frames with SS held low.
// Optional build macro SPI_LOOPBACK_EN: receive path samples the internal MOSI instead of MISO.
module spi_master_byte
   import spi_pkg::*;
#(
   parameter int CLK_DIV  = 8,
   parameter int SS_SETUP = 4,
   parameter int SS_HOLD  = 4,
   parameter int SS_GAP   = 4
) (
   input  logic              sysClk,
   input  logic              usrReset,
   input  logic [BYTE_W-1:0] txData,
   input  logic              txLast,
   input  logic              txValid,
   output logic              txReady,
   output logic [BYTE_W-1:0] rxData,
   output logic              rxValid,
   output logic              busy,
   output logic              SCLK,
   output logic              MOSI,
   input  logic              MISO,
   output logic              SS
);

   localparam int CNT_W = $clog2(max4(CLK_DIV, SS_SETUP, SS_HOLD, SS_GAP) + 1);

   spi_state_e        state, state_next;
   logic              load, done, ready_en, tx_ready_c, accept, rx_fire, rx_sent, sample;
   logic [CNT_W-1:0]  dwell;
   logic [BYTE_W-1:0] shift, rx_shift;
   logic              last;
   logic [2:0]        bit_idx;

`ifdef SPI_LOOPBACK_EN
   logic unused_miso;
   assign unused_miso = MISO;
   assign sample      = MOSI;
`else
   assign sample      = MISO;
`endif

   always_ff @(posedge sysClk or posedge usrReset) begin
      if (usrReset) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      tx_ready_c = 1'b0;
      rx_fire    = 1'b0;
      case (state)
         IDLE: begin
            tx_ready_c = 1'b1;
            if (txValid && ready_en) state_next = SETUP;
         end
         SETUP: if (done) state_next = LOW;
         LOW:   if (done) state_next = HIGH;
         HIGH: begin
            if (done) begin
               if (bit_idx != 3'd7) begin
                  state_next = LOW;
               end else begin
                  // Stalled frames sit here with done held; rx_sent keeps the strobe single.
                  rx_fire = !rx_sent;
                  if (last) begin
                     state_next = HOLD;
                  end else begin
                     tx_ready_c = 1'b1;
                     if (txValid) state_next = LOW;
                  end
               end
            end
         end
         HOLD:    if (done) state_next = GAP;
         GAP:     if (done) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign txReady = tx_ready_c && ready_en;
   assign accept  = txReady && txValid;
   assign load    = (state_next != state);

   always_comb begin
      dwell = CNT_W'(1);
      case (state_next)
         SETUP:     dwell = CNT_W'(SS_SETUP);
         LOW, HIGH: dwell = CNT_W'(CLK_DIV);
         HOLD:      dwell = CNT_W'(SS_HOLD);
         GAP:       dwell = CNT_W'(SS_GAP);
         default:   dwell = CNT_W'(1);
      endcase
   end

   spi_master_timer #(.W(CNT_W)) u_timer (
      .clk      (sysClk),
      .rst      (usrReset),
      .load     (load),
      .load_val (dwell),
      .done     (done)
   );

   always_ff @(posedge sysClk or posedge usrReset) begin
      if (usrReset) begin
         ready_en <= 1'b0;
         SCLK     <= CPOL;
         SS       <= 1'b1;
         MOSI     <= 1'b1;
         busy     <= 1'b0;
         rxValid  <= 1'b0;
         rxData   <= '0;
         rx_sent  <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         rxValid  <= rx_fire;
         if (rx_fire) rxData <= rx_shift;
         if (load)         rx_sent <= 1'b0;
         else if (rx_fire) rx_sent <= 1'b1;
         case (state)
            IDLE:  if (accept) begin SS <= 1'b0; busy <= 1'b1; end
            SETUP: if (done) begin SCLK <= 1'b0; MOSI <= shift[7]; end
            LOW:   if (done) SCLK <= 1'b1;
            HIGH: begin
               // Next byte of the frame takes its MSB straight from the port on the same fall.
               if (state_next == LOW) begin
                  SCLK <= 1'b0;
                  MOSI <= (bit_idx == 3'd7) ? txData[7] : shift[6];
               end
            end
            HOLD:    if (done) begin SS <= 1'b1; MOSI <= 1'b1; end
            GAP:     if (done) busy <= 1'b0;
            default: ;
         endcase
      end
   end

   always_ff @(posedge sysClk) begin
      if (accept) begin
         shift   <= txData;
         last    <= txLast;
         bit_idx <= '0;
      end else if (state == HIGH && state_next == LOW) begin
         shift   <= shift << 1;
         bit_idx <= bit_idx + 3'd1;
      end
      if (state == LOW && done) rx_shift <= {rx_shift[BYTE_W-2:0], sample};
   end

endmodule

// File: tb/tb_spi_master_byte.sv
// Directed bench for spi_master_byte with a mode-3 slave model on MISO.
module tb_spi_master_byte;

`ifdef SPI_LOOPBACK_EN
   localparam int CD = 1;
   localparam bit LOOP = 1'b1;
`else
   localparam int CD = 2;
   localparam bit LOOP = 1'b0;
`endif
   localparam int SU = 3;
   localparam int HO = 2;
   localparam int GP = 5;
   localparam int PER = 10;

   logic       sysClk = 1'b0;
   logic       usrReset, txLast, txValid, MISO;
   logic [7:0] txData, rxData;
   logic       txReady, rxValid, busy, SCLK, MOSI, SS;

   int pass_cnt = 0;
   int total_cnt = 0;

   int          rise_cnt, fall_cnt, ss_fall_cnt, rxv_cnt, ready_busy;
   logic [23:0] mosi_cap, rx_hist;
   time         last_edge, min_half, t_ss_fall, t_ss_rise, ss_low, ss_gap;
   bit          have_edge, ss_rose;
   logic [7:0]  sl [0:3];
   logic [2:0]  sl_bit;
   logic [1:0]  sl_idx;

   spi_master_byte #(.CLK_DIV(CD), .SS_SETUP(SU), .SS_HOLD(HO), .SS_GAP(GP)) dut (
      .sysClk(sysClk), .usrReset(usrReset), .txData(txData), .txLast(txLast),
      .txValid(txValid), .txReady(txReady), .rxData(rxData), .rxValid(rxValid),
      .busy(busy), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .SS(SS)
   );

   always #(PER/2) sysClk = ~sysClk;

   // Slave shifts on SCLK fall so the master sees each bit stable at the rise.
   always @(negedge SS) begin sl_bit = 3'd0; sl_idx = 2'd0; end
   always @(negedge SCLK) begin
      fall_cnt++;
      if (!SS) begin
         MISO = sl[sl_idx][~sl_bit];
         sl_bit = sl_bit + 3'd1;
         if (sl_bit == 3'd0) sl_idx = sl_idx + 2'd1;
      end
   end
   always @(posedge SCLK) begin
      rise_cnt++;
      mosi_cap = {mosi_cap[22:0], MOSI};
   end
   always @(SCLK) begin
      if (have_edge && !SS && !usrReset && ($time - last_edge) < min_half) min_half = $time - last_edge;
      last_edge = $time;
      have_edge = 1'b1;
   end
   always @(negedge SS) begin
      ss_fall_cnt++;
      t_ss_fall = $time;
      if (ss_rose) ss_gap = $time - t_ss_rise;
   end
   always @(posedge SS) begin
      t_ss_rise = $time;
      ss_rose = 1'b1;
      ss_low = $time - t_ss_fall;
   end
   always @(negedge sysClk) begin
      if (rxValid) begin rxv_cnt++; rx_hist = {rx_hist[15:0], rxData}; end
      if (txReady && busy) ready_busy++;
   end

   function automatic logic [7:0] exp_rx(input logic [7:0] tx, input logic [7:0] sb);
      return LOOP ? tx : sb;
   endfunction

   task automatic clear_mon();
      rise_cnt = 0; fall_cnt = 0; ss_fall_cnt = 0; rxv_cnt = 0; ready_busy = 0;
      mosi_cap = '0; rx_hist = '0; min_half = 64'd1000000; ss_low = 0; ss_gap = 0;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic l);
      int n;
      @(negedge sysClk);
      txData = d; txLast = l; txValid = 1'b1;
      n = 0;
      while (!txReady && n < 2000) begin @(negedge sysClk); n++; end
      total_cnt++;
      if (txReady !== 1'b1) $display("FAIL accept_%h: txReady=%b required 1 after %0d cycles", d, txReady, n);
      else pass_cnt++;
      @(posedge sysClk);
      #1 txValid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 3000) begin @(negedge sysClk); n++; end
      @(negedge sysClk);
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL idle_timeout: busy=%b required 0", busy); else pass_cnt++;
   endtask

   task automatic test_reset();
      usrReset = 1'b0; txValid = 1'b0; txData = '0; txLast = 1'b0; MISO = 1'b1;
      #2 usrReset = 1'b1;
      repeat (3) @(negedge sysClk);
      total_cnt += 7;
      if (SCLK !== 1'b1)    $display("FAIL rst_sclk: got %b required 1", SCLK); else pass_cnt++;
      if (SS !== 1'b1)      $display("FAIL rst_ss: got %b required 1", SS); else pass_cnt++;
      if (MOSI !== 1'b1)    $display("FAIL rst_mosi: got %b required 1", MOSI); else pass_cnt++;
      if (txReady !== 1'b0) $display("FAIL rst_ready: got %b required 0", txReady); else pass_cnt++;
      if (rxValid !== 1'b0) $display("FAIL rst_rxvalid: got %b required 0", rxValid); else pass_cnt++;
      if (rxData !== 8'h00) $display("FAIL rst_rxdata: got %h required 00", rxData); else pass_cnt++;
      if (busy !== 1'b0)    $display("FAIL rst_busy: got %b required 0", busy); else pass_cnt++;
      #2 usrReset = 1'b0;
      #1 total_cnt++;
      if (txReady !== 1'b0) $display("FAIL ready_before_clk: got %b required 0", txReady); else pass_cnt++;
      @(negedge sysClk);
      total_cnt++;
      if (txReady !== 1'b1) $display("FAIL ready_after_clk: got %b required 1", txReady); else pass_cnt++;
   endtask

   task automatic test_single();
      clear_mon();
      sl[0] = 8'h55;
      send_byte(8'hAA, 1'b1);
      wait_idle();
      total_cnt += 8;
      if (mosi_cap[7:0] !== 8'hAA) $display("FAIL single_mosi: got %h required aa", mosi_cap[7:0]); else pass_cnt++;
      if (rise_cnt != 8) $display("FAIL single_rises: got %0d required 8", rise_cnt); else pass_cnt++;
      if (fall_cnt != 8) $display("FAIL single_falls: got %0d required 8", fall_cnt); else pass_cnt++;
      if (rxv_cnt != 1)  $display("FAIL single_rxvalid: got %0d required 1", rxv_cnt); else pass_cnt++;
      if (rxData !== exp_rx(8'hAA, 8'h55)) $display("FAIL single_rxdata: got %h required %h", rxData, exp_rx(8'hAA, 8'h55)); else pass_cnt++;
      if (ss_low != time'((SU + 16*CD + HO) * PER)) $display("FAIL single_ss_low: got %0d required %0d", ss_low, (SU + 16*CD + HO) * PER); else pass_cnt++;
      if (MOSI !== 1'b1 || SCLK !== 1'b1 || SS !== 1'b1) $display("FAIL single_idle_lines: got %b%b%b required 111", MOSI, SCLK, SS); else pass_cnt++;
      if (min_half != time'(CD * PER)) $display("FAIL single_half: got %0d required %0d", min_half, CD * PER); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      clear_mon();
      sl[0] = 8'hA1; sl[1] = 8'h5E;
      send_byte(8'h12, 1'b0);
      send_byte(8'h34, 1'b1);
      wait_idle();
      total_cnt += 7;
      if (ss_fall_cnt != 1) $display("FAIL b2b_ss_falls: got %0d required 1", ss_fall_cnt); else pass_cnt++;
      if (rise_cnt != 16 || fall_cnt != 16) $display("FAIL b2b_edges: got %0d/%0d required 16/16", rise_cnt, fall_cnt); else pass_cnt++;
      if (mosi_cap[15:0] !== 16'h1234) $display("FAIL b2b_mosi: got %h required 1234", mosi_cap[15:0]); else pass_cnt++;
      if (rxv_cnt != 2) $display("FAIL b2b_rxvalid: got %0d required 2", rxv_cnt); else pass_cnt++;
      if (rx_hist[15:0] !== {exp_rx(8'h12, 8'hA1), exp_rx(8'h34, 8'h5E)})
         $display("FAIL b2b_rxdata: got %h required %h%h", rx_hist[15:0], exp_rx(8'h12, 8'hA1), exp_rx(8'h34, 8'h5E));
      else pass_cnt++;
      if (min_half != time'(CD * PER)) $display("FAIL b2b_half: got %0d required %0d", min_half, CD * PER); else pass_cnt++;
      if (ss_low != time'((SU + 32*CD + HO) * PER)) $display("FAIL b2b_ss_low: got %0d required %0d", ss_low, (SU + 32*CD + HO) * PER); else pass_cnt++;
   endtask

   task automatic test_stall();
      int n;
      clear_mon();
      sl[0] = 8'hC6; sl[1] = 8'h69;
      send_byte(8'h3C, 1'b0);
      n = 0;
      while (rxv_cnt < 1 && n < 2000) begin @(negedge sysClk); n++; end
      repeat (50) @(negedge sysClk);
      total_cnt += 5;
      if (SCLK !== 1'b1)    $display("FAIL stall_sclk: got %b required 1", SCLK); else pass_cnt++;
      if (SS !== 1'b0)      $display("FAIL stall_ss: got %b required 0", SS); else pass_cnt++;
      if (txReady !== 1'b1) $display("FAIL stall_ready: got %b required 1", txReady); else pass_cnt++;
      if (rise_cnt != 8)    $display("FAIL stall_rises: got %0d required 8", rise_cnt); else pass_cnt++;
      if (rxData !== exp_rx(8'h3C, 8'hC6)) $display("FAIL stall_rx0: got %h required %h", rxData, exp_rx(8'h3C, 8'hC6)); else pass_cnt++;
      send_byte(8'h96, 1'b1);
      wait_idle();
      total_cnt += 5;
      if (mosi_cap[15:0] !== 16'h3C96) $display("FAIL stall_mosi: got %h required 3c96", mosi_cap[15:0]); else pass_cnt++;
      if (rise_cnt != 16) $display("FAIL stall_rises_total: got %0d required 16", rise_cnt); else pass_cnt++;
      if (rx_hist[15:0] !== {exp_rx(8'h3C, 8'hC6), exp_rx(8'h96, 8'h69)})
         $display("FAIL stall_rxdata: got %h required %h%h", rx_hist[15:0], exp_rx(8'h3C, 8'hC6), exp_rx(8'h96, 8'h69));
      else pass_cnt++;
      if (ss_fall_cnt != 1) $display("FAIL stall_ss_falls: got %0d required 1", ss_fall_cnt); else pass_cnt++;
      if (min_half != time'(CD * PER)) $display("FAIL stall_half: got %0d required %0d", min_half, CD * PER); else pass_cnt++;
   endtask

   task automatic test_busy_hold();
      int n;
      clear_mon();
      sl[0] = 8'h0F;
      @(negedge sysClk);
      txData = 8'h5A; txLast = 1'b1; txValid = 1'b1;
      n = 0;
      while (!txReady && n < 2000) begin @(negedge sysClk); n++; end
      @(posedge sysClk);
      #1 txData = 8'hE7;
      @(negedge sysClk);
      n = 0;
      while (!txReady && n < 3000) begin @(negedge sysClk); n++; end
      total_cnt++;
      if (txReady !== 1'b1) $display("FAIL hold_accept2: txReady=%b required 1", txReady); else pass_cnt++;
      @(posedge sysClk);
      #1 txValid = 1'b0;
      wait_idle();
      total_cnt += 6;
      if (ready_busy != 0) $display("FAIL hold_ready_busy: got %0d cycles required 0", ready_busy); else pass_cnt++;
      if (ss_gap < time'(GP * PER)) $display("FAIL hold_gap_min: got %0d required >= %0d", ss_gap, GP * PER); else pass_cnt++;
      if (ss_gap != time'((GP + 1) * PER)) $display("FAIL hold_gap: got %0d required %0d", ss_gap, (GP + 1) * PER); else pass_cnt++;
      if (mosi_cap[15:0] !== 16'h5AE7) $display("FAIL hold_mosi: got %h required 5ae7", mosi_cap[15:0]); else pass_cnt++;
      if (rxv_cnt != 2) $display("FAIL hold_rxvalid: got %0d required 2", rxv_cnt); else pass_cnt++;
      if (ss_fall_cnt != 2) $display("FAIL hold_ss_falls: got %0d required 2", ss_fall_cnt); else pass_cnt++;
   endtask

   task automatic test_abort();
      int n;
      clear_mon();
      sl[0] = 8'hFF;
      send_byte(8'h81, 1'b1);
      n = 0;
      while (fall_cnt < 5 && n < 2000) begin @(negedge sysClk); n++; end
      @(negedge sysClk);
      usrReset = 1'b1;
      #1 total_cnt += 6;
      if (SS !== 1'b1)      $display("FAIL abort_ss: got %b required 1", SS); else pass_cnt++;
      if (SCLK !== 1'b1)    $display("FAIL abort_sclk: got %b required 1", SCLK); else pass_cnt++;
      if (MOSI !== 1'b1)    $display("FAIL abort_mosi: got %b required 1", MOSI); else pass_cnt++;
      if (busy !== 1'b0)    $display("FAIL abort_busy: got %b required 0", busy); else pass_cnt++;
      if (txReady !== 1'b0) $display("FAIL abort_ready: got %b required 0", txReady); else pass_cnt++;
      if (fall_cnt != 5)    $display("FAIL abort_point: got %0d falls required 5", fall_cnt); else pass_cnt++;
      repeat (3) @(negedge sysClk);
      usrReset = 1'b0;
      @(negedge sysClk);
      total_cnt++;
      if (rxv_cnt != 0) $display("FAIL abort_rxvalid: got %0d required 0", rxv_cnt); else pass_cnt++;
      clear_mon();
      sl[0] = 8'h3C;
      send_byte(8'hC3, 1'b1);
      wait_idle();
      total_cnt += 4;
      if (mosi_cap[7:0] !== 8'hC3) $display("FAIL post_abort_mosi: got %h required c3", mosi_cap[7:0]); else pass_cnt++;
      if (rise_cnt != 8) $display("FAIL post_abort_rises: got %0d required 8", rise_cnt); else pass_cnt++;
      if (rxv_cnt != 1) $display("FAIL post_abort_rxvalid: got %0d required 1", rxv_cnt); else pass_cnt++;
      if (rxData !== exp_rx(8'hC3, 8'h3C)) $display("FAIL post_abort_rxdata: got %h required %h", rxData, exp_rx(8'hC3, 8'h3C)); else pass_cnt++;
   endtask

`ifdef SPI_LOOPBACK_EN
   task automatic test_loopback();
      clear_mon();
      send_byte(8'h00, 1'b0);
      send_byte(8'hFF, 1'b0);
      send_byte(8'hA5, 1'b1);
      wait_idle();
      total_cnt += 4;
      if (rxv_cnt != 3) $display("FAIL loop_rxvalid: got %0d required 3", rxv_cnt); else pass_cnt++;
      if (rx_hist !== 24'h00FFA5) $display("FAIL loop_rxdata: got %h required 00ffa5", rx_hist); else pass_cnt++;
      if (mosi_cap !== 24'h00FFA5) $display("FAIL loop_mosi: got %h required 00ffa5", mosi_cap); else pass_cnt++;
      if (min_half != time'(PER)) $display("FAIL loop_half: got %0d required %0d", min_half, PER); else pass_cnt++;
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      have_edge = 1'b0; ss_rose = 1'b0; last_edge = 0; t_ss_fall = 0; t_ss_rise = 0;
      sl_bit = 3'd0; sl_idx = 2'd0;
      sl[0] = 8'h00; sl[1] = 8'h00; sl[2] = 8'h00; sl[3] = 8'h00;
      clear_mon();
      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_busy_hold();
      test_abort();
`ifdef SPI_LOOPBACK_EN
      test_loopback();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
